// File: rtl/pixel_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_framebuffer
// Brief    : 160x120 x 3-bit colour store: plot writes, 1-cycle read-back and
//            a valid/ready raster scan-out. Optional macro FB_CLEAR_ON_RESET_EN
//            adds a reset clear sweep; without it reset enters RUN directly.
// Revision : 1.0
// ============================================================================
module pixel_framebuffer #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       plot,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic [2:0] rd_colour,
  input  logic       scan_ready,
  output logic       scan_valid,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_sof,
  output logic       busy
);

  localparam int          DEPTH     = WIDTH * HEIGHT;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
  localparam logic [7:0]  X_MAX     = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_MAX     = 7'(HEIGHT - 1);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_RUN;
`endif

  // Row stride of 160 built as 128 + 32 so no multiplier is needed.
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
  endfunction

  logic [2:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic [7:0]  rast_x_q, rast_x_d;
  logic [6:0]  rast_y_q, rast_y_d;
  logic        a_valid_q, a_valid_d;
  logic [7:0]  a_x_q, a_x_d;
  logic [6:0]  a_y_q, a_y_d;
  logic [14:0] a_addr_q, a_addr_d;
  logic [2:0]  rd_colour_q, rd_colour_d;
  logic        scan_valid_q, scan_valid_d;
  logic [7:0]  scan_x_q, scan_x_d;
  logic [6:0]  scan_y_q, scan_y_d;
  logic [2:0]  scan_colour_q, scan_colour_d;
  logic        scan_sof_q, scan_sof_d;

  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;
  logic        wr_in_range, rd_in_range, advance;
  logic [14:0] rd_addr;

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    rast_x_d      = rast_x_q;
    rast_y_d      = rast_y_q;
    a_valid_d     = a_valid_q;
    a_x_d         = a_x_q;
    a_y_d         = a_y_q;
    a_addr_d      = a_addr_q;
    scan_valid_d  = scan_valid_q;
    scan_x_d      = scan_x_q;
    scan_y_d      = scan_y_q;
    scan_colour_d = scan_colour_q;
    scan_sof_d    = scan_sof_q;

    wr_in_range = (x_in <= X_MAX) && (y_in <= Y_MAX);
    rd_in_range = (rd_x <= X_MAX) && (rd_y <= Y_MAX);
    rd_addr     = pix_addr(rd_x, rd_y);

    mem_we    = 1'b0;
    mem_waddr = pix_addr(x_in, y_in);
    mem_wdata = colour_in;

    if (state_q == S_CLEAR) begin
      mem_we      = 1'b1;
      mem_waddr   = clr_addr_q;
      mem_wdata   = CLEAR_COLOUR;
      clr_addr_d  = clr_addr_q + 15'd1;
      rd_colour_d = CLEAR_COLOUR;
      if (clr_addr_q == LAST_ADDR) state_d = S_RUN;
    end else begin
      mem_we      = plot && wr_in_range;
      rd_colour_d = rd_in_range ? mem[rd_addr] : 3'b000;
    end

    // Whole scan pipe moves together: on a transfer or while the output is empty.
    advance = (state_q == S_RUN) && (!scan_valid_q || scan_ready);
    if (advance) begin
      scan_valid_d  = a_valid_q;
      scan_x_d      = a_x_q;
      scan_y_d      = a_y_q;
      scan_colour_d = mem[a_addr_q];
      scan_sof_d    = a_valid_q && (a_x_q == 8'd0) && (a_y_q == 7'd0);
      a_valid_d     = 1'b1;
      a_x_d         = rast_x_q;
      a_y_d         = rast_y_q;
      a_addr_d      = pix_addr(rast_x_q, rast_y_q);
      if (rast_x_q == X_MAX) begin
        rast_x_d = 8'd0;
        rast_y_d = (rast_y_q == Y_MAX) ? 7'd0 : rast_y_q + 7'd1;
      end else begin
        rast_x_d = rast_x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RESET_STATE;
      clr_addr_q    <= 15'd0;
      rast_x_q      <= 8'd0;
      rast_y_q      <= 7'd0;
      a_valid_q     <= 1'b0;
      a_x_q         <= 8'd0;
      a_y_q         <= 7'd0;
      a_addr_q      <= 15'd0;
      rd_colour_q   <= 3'b000;
      scan_valid_q  <= 1'b0;
      scan_x_q      <= 8'd0;
      scan_y_q      <= 7'd0;
      scan_colour_q <= 3'b000;
      scan_sof_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      rast_x_q      <= rast_x_d;
      rast_y_q      <= rast_y_d;
      a_valid_q     <= a_valid_d;
      a_x_q         <= a_x_d;
      a_y_q         <= a_y_d;
      a_addr_q      <= a_addr_d;
      rd_colour_q   <= rd_colour_d;
      scan_valid_q  <= scan_valid_d;
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      scan_colour_q <= scan_colour_d;
      scan_sof_q    <= scan_sof_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_colour   = rd_colour_q;
  assign scan_valid  = scan_valid_q;
  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign scan_colour = scan_colour_q;
  assign scan_sof    = scan_sof_q;

`ifdef FB_CLEAR_ON_RESET_EN
  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_framebuffer
// Brief    : Directed self-checking bench for pixel_framebuffer (both builds).
// Revision : 1.0
// ============================================================================
module tb_pixel_framebuffer;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;
  localparam int TAIL = 320;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       plot = 1'b0;
  logic [7:0] x_in = 8'd0;
  logic [6:0] y_in = 7'd0;
  logic [2:0] colour_in = 3'b000;
  logic [7:0] rd_x = 8'd0;
  logic [6:0] rd_y = 7'd0;
  logic [2:0] rd_colour;
  logic       scan_ready = 1'b0;
  logic       scan_valid;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_sof;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] model [NPIX];

  pixel_framebuffer dut (
    .clk(clk), .rst(rst), .plot(plot), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .scan_ready(scan_ready), .scan_valid(scan_valid), .scan_x(scan_x),
    .scan_y(scan_y), .scan_colour(scan_colour), .scan_sof(scan_sof), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    plot = 1'b1; x_in = x[7:0]; y_in = y[6:0]; colour_in = c;
    @(negedge clk);
    plot = 1'b0;
    if (x < W && y < H) model[y*W + x] = c;
  endtask

  task automatic rd_chk(input string tag, input int x, input int y, input logic [2:0] exp);
    rd_x = x[7:0]; rd_y = y[6:0];
    @(negedge clk);
    check(tag, 32'(rd_colour), 32'(exp));
  endtask

  // Called in the cycle the pipe is empty: valid rises on the second edge.
  task automatic first_beat_chk(input logic [2:0] exp);
    check("first_valid_c0", 32'(scan_valid), 32'd0);
    @(negedge clk);
    check("first_valid_c1", 32'(scan_valid), 32'd0);
    @(negedge clk);
    check("first_beat", 32'({scan_valid, scan_sof, scan_x, scan_y, scan_colour}),
          32'({1'b1, 1'b1, 8'd0, 7'd0, exp}));
  endtask

`ifdef FB_CLEAR_ON_RESET_EN
  task automatic wait_clear(input bit hold_plot);
    int n;
    n = 0;
    if (hold_plot) begin
      plot = 1'b1; x_in = 8'd10; y_in = 7'd10; colour_in = 3'b011;
    end
    while (busy === 1'b1 && n < 25000) begin
      n++;
      @(negedge clk);
    end
    plot = 1'b0;
    check("clear_cycles", 32'(n), 32'(NPIX));
  endtask
`endif

  task automatic scan_frame();
    int         ex, ey, beats, cyc, tail;
    bit         stalled;
    logic       r;
    logic [2:0] ec;
    logic [31:0] held;
    ex = 0; ey = 0; beats = 0; cyc = 0; tail = 0; stalled = 1'b0; held = '0;
    while (beats < NPIX + 1 + TAIL && cyc < 60000) begin
      if (stalled)
        check("scan_hold", 32'({scan_valid, scan_sof, scan_x, scan_y, scan_colour}), held);
      if (beats > NPIX) tail++;
      r = (beats > NPIX) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      scan_ready = r;
      if (scan_valid && r) begin
        // (0,0) was latched before the drawing, so its write lands next frame.
        ec = (beats == 0) ? 3'b000 : model[ey*W + ex];
        check("scan_beat", 32'({scan_sof, scan_x, scan_y, scan_colour}),
              32'({1'((ex == 0) && (ey == 0)), 8'(ex), 7'(ey), ec}));
        beats++;
        stalled = 1'b0;
        if (ex == W - 1) begin
          ex = 0;
          ey = (ey == H - 1) ? 0 : ey + 1;
        end else begin
          ex++;
        end
      end else begin
        stalled = scan_valid;
        held = 32'({scan_valid, scan_sof, scan_x, scan_y, scan_colour});
      end
      cyc++;
      @(negedge clk);
    end
    scan_ready = 1'b0;
    check("scan_beats", 32'(beats), 32'(NPIX + 1 + TAIL));
    check("scan_tail_cycles", 32'(tail), 32'(TAIL));
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) model[i] = 3'b000;

    @(negedge clk);
    check("rst_rd_colour", 32'(rd_colour), 32'd0);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_xy", 32'({scan_x, scan_y}), 32'd0);
    check("rst_scan_colour_sof", 32'({scan_colour, scan_sof}), 32'd0);
`ifdef FB_CLEAR_ON_RESET_EN
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_clear(1'b1);
    first_beat_chk(3'b000);
    rd_chk("clear_plot_ignored", 10, 10, 3'b000);
`else
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int a = 0; a < NPIX; a++) wr(a % W, a / W, 3'b000);
    pulse_rst();
    first_beat_chk(3'b000);
    check("busy_run", 32'(busy), 32'd0);
`endif

    // Write and read the corner in the same cycle: old value first.
    rd_x = 8'd159; rd_y = 7'd119;
    plot = 1'b1; x_in = 8'd159; y_in = 7'd119; colour_in = 3'b101;
    @(negedge clk);
    plot = 1'b0;
    model[119*W + 159] = 3'b101;
    check("rd_during_write", 32'(rd_colour), 32'd0);
    @(negedge clk);
    check("rd_after_write", 32'(rd_colour), 32'(3'b101));

    // (160,5) would alias (0,6) if the range check were missing.
    wr(0, 6, 3'b110);
    wr(160, 5, 3'b111);
    wr(3, 120, 3'b111);
    rd_chk("rd_oor_x", 160, 5, 3'b000);
    rd_chk("rd_oor_y", 3, 120, 3'b000);
    rd_chk("rd_alias_target", 0, 6, 3'b110);
    rd_chk("rd_row5_start", 0, 5, 3'b000);

    for (int i = 0; i < H; i++) wr(i, i, 3'b010);
    wr(159, 0, 3'b001);
    wr(0, 119, 3'b100);
    rd_chk("rd_diag", 50, 50, 3'b010);
    rd_chk("rd_off_diag", 51, 50, 3'b000);
    rd_chk("rd_top_right", 159, 0, 3'b001);
    rd_chk("rd_bottom_left", 0, 119, 3'b100);

    scan_frame();

`ifdef FB_CLEAR_ON_RESET_EN
    pulse_rst();
    repeat (9000) @(negedge clk);
    check("busy_mid_sweep", 32'(busy), 32'd1);
    pulse_rst();
    wait_clear(1'b1);
    first_beat_chk(3'b000);
    rd_chk("cleared_corner", 159, 119, 3'b000);
    rd_chk("cleared_diag", 50, 50, 3'b000);
    rd_chk("cleared_alias", 0, 6, 3'b000);
    rd_chk("cleared_plot_ignored", 10, 10, 3'b000);
`else
    pulse_rst();
    first_beat_chk(3'b010);
    rd_chk("retained_corner", 159, 119, 3'b101);
    rd_chk("retained_diag", 7, 7, 3'b010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Pixel sink and colour store for the 160x120, 3-bit-colour display plane. Accepts the game's `plot`/x/y/colour write stream (snake, title, game-over and black-fill drawing). Answers single-pixel colour read-backs used for collision and food detection. Streams the stored image in raster order to the display side over a valid/ready handshake. Sits between the game interface's pixel outputs and the display scan-out.

## Interface
Parameters:
- `WIDTH`, 160: pixels per row.
- `HEIGHT`, 120: rows.
- `CLEAR_COLOUR`, 3'b000: colour written by the reset sweep.

Ports:
- `clk`  in  1: system clock (50 MHz).
- `rst`  in  1: reset; one clock, reset is synchronous and active-high.
- `plot`  in  1: write strobe; one pixel is written per cycle while high.
- `x_in`  in  8: write column.
- `y_in`  in  7: write row.
- `colour_in`  in  3: write colour.
- `rd_x`  in  8: read-back column, sampled every cycle.
- `rd_y`  in  7: read-back row, sampled every cycle.
- `rd_colour`  out  3: read-back colour for the previous cycle's `rd_x`/`rd_y`.
- `scan_ready`  in  1: display sink accepts the current beat.
- `scan_valid`  out  1: scan beat present.
- `scan_x`  out  8: column of the current beat.
- `scan_y`  out  7: row of the current beat.
- `scan_colour`  out  3: colour of the current beat.
- `scan_sof`  out  1: high on the (0,0) beat.
- `busy`  out  1: clear sweep in progress.

## Operation
- Storage: WIDTH*HEIGHT words of 3 bits.
  - Address is the 15-bit value y*160 + x, computed as (y<<7)+(y<<5)+x.
  - Storage has one write port and two read ports (read-back, scan).
- States:
  - CLEAR: a sweep counter writes CLEAR_COLOUR to addresses 0..19199, one per cycle. `busy`=1. `plot` is ignored. `rd_colour`=CLEAR_COLOUR. `scan_valid`=0.
  - RUN: entered the cycle after address 19199 is written. Stays in RUN until `rst`.
- Writes (RUN only):
  - When `plot`=1 and x<WIDTH and y<HEIGHT, the addressed word takes `colour_in` at the clock edge.
  - Out-of-range writes are dropped silently.
- Read-back:
  - `rd_colour` is registered and is read-before-write: the same-cycle write to the same address is not visible until the next read.
  - Out-of-range coordinates return 3'b000.
- Scan-out:
  - A raster counter (x fastest) addresses the scan port.
  - An output register holds `scan_x`/`scan_y`/`scan_colour`/`scan_sof`.
  - A beat transfers on `scan_valid` & `scan_ready`. The raster counter advances only on a transfer or while the output register is empty.
  - While `scan_valid`=1 and `scan_ready`=0, all scan outputs hold stable.
  - After (159,119) the counter wraps to (0,0); `scan_sof` is set on that beat.
  - Writes racing the scan position appear on the next frame. Tearing is acceptable.

## Timing
- Reset values: `rd_colour`=0, `scan_valid`=0, `scan_x`=0, `scan_y`=0, `scan_colour`=0, `scan_sof`=0.
  - `busy`=1 with FB_CLEAR_ON_RESET_EN defined; `busy`=0 without it.
- Clear sweep:
  - Lasts 19200 cycles starting the first cycle after `rst` falls.
  - `busy` drops on cycle 19201.
  - `rst` asserted mid-sweep restarts the sweep at address 0.
- Read-back latency: 1 cycle.
- Write-to-read visibility: a write at edge N is returned by a read presented in cycle N+1, with `rd_colour` valid after edge N+1.
- Scan-out:
  - First `scan_valid` occurs 2 cycles after entering RUN (1 cycle address, 1 cycle register).
  - With `scan_ready` held at 1, sustained throughput is 1 beat/cycle: 19200 cycles per frame.
- Reset mid-RUN: state returns to CLEAR (or RUN with contents retained if the macro is undefined) and the raster counter returns to (0,0).

## Configuration
- `FB_CLEAR_ON_RESET_EN` defined: the CLEAR sweep runs after every reset, exactly as above.
- Undefined:
  - Reset enters RUN directly with `busy` tied to 0.
  - Memory contents are left unchanged and are undefined at power-up.
  - Scan and read-back operate immediately after reset.

## Test plan
- Reset 1 cycle, hold `scan_ready`=1 -> `busy` high for exactly 19200 cycles. After `busy` falls, a full frame reads 19200 beats of 3'b000, with `scan_sof` only on (0,0).
- In RUN, `plot`=1 at (159,119) colour 3'b101, then `rd_x`/`rd_y`=(159,119) next cycle -> `rd_colour`=3'b101 one cycle later. The same cycle as the write returns the old value 3'b000.
- `plot` at (160,5) and (3,120) with colour 3'b111 -> no stored word changes; reads at (160,5) return 3'b000. The full-frame scan stays all-zero.
- Toggle `scan_ready` randomly for 2 frames after writing a diagonal of 3'b010 -> beat sequence is unbroken in raster order with the diagonal at x=y. Outputs are stable across every stalled cycle, and the frame wraps (159,119) -> (0,0).
- Assert `rst` at sweep address 9000 after writing pixels in an earlier RUN -> `busy` stays high 19200 further cycles. All pixels read 3'b000 afterwards.
- `plot` held high during CLEAR at (10,10) colour 3'b011 -> read at (10,10) after `busy` falls returns 3'b000.
